// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a START/BUSY/DONE handshake, an iterative signed
// multiplier (full 2*WIDTH product) and iterative shift/rotate operations.
module seq_alu #(
  parameter  int WIDTH = 8,
  localparam int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO,
  output logic             OVF
);
  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;
  localparam int LOGW = $clog2(WIDTH);
  localparam logic [CNTW-1:0]    CNT_FULL  = CNTW'(WIDTH);
  localparam logic [CNTW-1:0]    CNT_ONE   = CNTW'(1);
  localparam logic [WIDTH-1:0]   W_AS_DATA = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W    = (2*WIDTH)'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_SHIFT = 2'd2, S_FIN = 2'd3} state_t;

  state_t             state_r;
  logic [CNTW-1:0]    cnt_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   sh_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               neg_r;

  logic               accept_s;
  logic               is_quick_s;
  logic [WIDTH-1:0]   add_sum_s;
  logic               add_ovf_s;
  logic [WIDTH-1:0]   quick_res_s;
  logic               quick_ovf_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [CNTW-1:0]    sh_cnt_s;
  logic [WIDTH-1:0]   sh_next_s;
  logic [WIDTH:0]     step_sum_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;

  // Request decode, single-cycle datapath, shift step and multiplier step
  always_comb begin
    accept_s  = START && ((state_r == S_IDLE) || (state_r == S_FIN));
    add_sum_s = DATA1 + DATA2;
    add_ovf_s = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (add_sum_s[WIDTH-1] != DATA1[WIDTH-1]);
    abs_a_s   = DATA1[WIDTH-1] ? (~DATA1 + ONE_W) : DATA1;
    abs_b_s   = DATA2[WIDTH-1] ? (~DATA2 + ONE_W) : DATA2;

    if (SELECT == OP_ROR) begin
      sh_cnt_s = CNTW'(DATA2[LOGW-1:0]);
    end else if (DATA2 >= W_AS_DATA) begin
      sh_cnt_s = CNT_FULL;
    end else begin
      sh_cnt_s = DATA2[CNTW-1:0];
    end

    quick_ovf_s = 1'b0;
    case (SELECT)
      OP_FWD:  begin quick_res_s = DATA2;         is_quick_s = 1'b1; end
      OP_ADD:  begin quick_res_s = add_sum_s;     is_quick_s = 1'b1; quick_ovf_s = add_ovf_s; end
      OP_AND:  begin quick_res_s = DATA1 & DATA2; is_quick_s = 1'b1; end
      OP_OR:   begin quick_res_s = DATA1 | DATA2; is_quick_s = 1'b1; end
      OP_MUL:  begin quick_res_s = DATA1;         is_quick_s = 1'b0; end
      default: begin quick_res_s = DATA1;         is_quick_s = (sh_cnt_s == '0); end
    endcase

    case (op_r)
      OP_SLL:  sh_next_s = {sh_r[WIDTH-2:0], 1'b0};
      OP_SRA:  sh_next_s = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]};
      OP_ROR:  sh_next_s = {sh_r[0], sh_r[WIDTH-1:1]};
      default: sh_next_s = sh_r;
    endcase

    // Unsigned shift-add on magnitudes: upper half accumulates, lower half holds the multiplier
    step_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, mcand_r} : '0);
    acc_next_s = {step_sum_s, acc_r[WIDTH-1:1]};
    prod_s     = neg_r ? (~acc_next_s + ONE_2W) : acc_next_s;
  end

  // Operation sequencer and registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      op_r      <= 3'b000;
      mcand_r   <= '0;
      sh_r      <= '0;
      acc_r     <= '0;
      neg_r     <= 1'b0;
      RESULT    <= '0;
      RESULT_HI <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ZERO      <= 1'b0;
      OVF       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_FIN: begin
          if (accept_s) begin
            op_r <= SELECT;
            if (is_quick_s) begin
              RESULT    <= quick_res_s;
              RESULT_HI <= '0;
              ZERO      <= (quick_res_s == '0);
              OVF       <= quick_ovf_s;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              state_r   <= S_FIN;
            end else if (SELECT == OP_MUL) begin
              mcand_r <= abs_a_s;
              acc_r   <= {{WIDTH{1'b0}}, abs_b_s};
              neg_r   <= DATA1[WIDTH-1] ^ DATA2[WIDTH-1];
              cnt_r   <= CNT_FULL;
              BUSY    <= 1'b1;
              DONE    <= 1'b0;
              state_r <= S_MUL;
            end else begin
              sh_r    <= DATA1;
              cnt_r   <= sh_cnt_s;
              BUSY    <= 1'b1;
              DONE    <= 1'b0;
              state_r <= S_SHIFT;
            end
          end else begin
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            RESULT    <= prod_s[WIDTH-1:0];
            RESULT_HI <= prod_s[2*WIDTH-1:WIDTH];
            ZERO      <= (prod_s[WIDTH-1:0] == '0);
            OVF       <= (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            state_r   <= S_FIN;
          end else begin
            state_r <= S_MUL;
          end
        end
        S_SHIFT: begin
          sh_r  <= sh_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            RESULT    <= sh_next_s;
            RESULT_HI <= '0;
            ZERO      <= (sh_next_s == '0);
            OVF       <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            state_r   <= S_FIN;
          end else begin
            state_r <= S_SHIFT;
          end
        end
        default: begin
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: table of hand-computed vectors plus sequences for
// ignored START, back-to-back START in FIN, async reset mid-multiply and WIDTH=16.
module tb_seq_alu;
  logic        CLK;
  logic        RESET;
  logic        START;
  logic [2:0]  SELECT;
  logic [7:0]  DATA1, DATA2, RESULT, RESULT_HI;
  logic        BUSY, DONE, ZERO, OVF;

  logic        start16;
  logic [2:0]  sel16;
  logic [15:0] a16, b16, res16, hi16;
  logic        busy16, done16, zero16, ovf16;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT), .DATA1(DATA1), .DATA2(DATA2),
    .RESULT(RESULT), .RESULT_HI(RESULT_HI), .BUSY(BUSY), .DONE(DONE), .ZERO(ZERO), .OVF(OVF)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .START(start16), .SELECT(sel16), .DATA1(a16), .DATA2(b16),
    .RESULT(res16), .RESULT_HI(hi16), .BUSY(busy16), .DONE(done16), .ZERO(zero16), .OVF(ovf16)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic       zero;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive a request so that the next rising edge is e0; returns #1 after e0.
  task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    START  = 1'b1;
    SELECT = sel;
    DATA1  = a;
    DATA2  = b;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Counts edges after the last accepted edge until DONE is seen (sampled on negedges).
  task automatic wait_done(output int lat, output int busy_n, output logic seen);
    lat    = 0;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      if (BUSY) busy_n++;
      @(posedge CLK);
      lat++;
    end
  endtask

  int   lat, busy_n, lat16;
  logic seen, seen16;

  initial begin
    vecs[0]  = '{3'b001, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 0};
    vecs[1]  = '{3'b001, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 0};
    vecs[2]  = '{3'b100, 8'hFD, 8'h05, 8'hF1, 8'hFF, 1'b0, 1'b0, 8};
    vecs[3]  = '{3'b100, 8'h80, 8'h80, 8'h00, 8'h40, 1'b1, 1'b1, 8};
    vecs[4]  = '{3'b110, 8'h90, 8'h02, 8'hE4, 8'h00, 1'b0, 1'b0, 2};
    vecs[5]  = '{3'b110, 8'h90, 8'h00, 8'h90, 8'h00, 1'b0, 1'b0, 0};
    vecs[6]  = '{3'b101, 8'h01, 8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 8};
    vecs[7]  = '{3'b111, 8'h81, 8'h09, 8'hC0, 8'h00, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'b000, 8'hAA, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 0};
    vecs[9]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 0};
    vecs[10] = '{3'b011, 8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b0, 0};
    vecs[11] = '{3'b100, 8'h07, 8'h06, 8'h2A, 8'h00, 1'b0, 1'b0, 8};
    vecs[12] = '{3'b100, 8'h7F, 8'h7F, 8'h01, 8'h3F, 1'b0, 1'b1, 8};
    vecs[13] = '{3'b111, 8'h81, 8'h04, 8'h18, 8'h00, 1'b0, 1'b0, 4};
    vecs[14] = '{3'b101, 8'h03, 8'h03, 8'h18, 8'h00, 1'b0, 1'b0, 3};
    vecs[15] = '{3'b110, 8'h40, 8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 8};
    vecs[16] = '{3'b110, 8'h80, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
    vecs[17] = '{3'b001, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 0};
    vecs[18] = '{3'b100, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 8};
    vecs[19] = '{3'b100, 8'h80, 8'h01, 8'h80, 8'hFF, 1'b0, 1'b0, 8};

    RESET = 1'b0; START = 1'b0; SELECT = 3'b000; DATA1 = 8'h00; DATA2 = 8'h00;
    start16 = 1'b0; sel16 = 3'b000; a16 = 16'h0000; b16 = 16'h0000;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {12'h000, RESULT, RESULT_HI, BUSY, DONE, ZERO, OVF}, 32'h0);
    RESET = 1'b1;

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].sel, vecs[i].a, vecs[i].b);
      wait_done(lat, busy_n, seen);
      chk($sformatf("v%0d_done_seen", i), {31'h0, seen}, 32'h1);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].lat);
      chk($sformatf("v%0d_result", i), {24'h0, RESULT}, {24'h0, vecs[i].res});
      chk($sformatf("v%0d_result_hi", i), {24'h0, RESULT_HI}, {24'h0, vecs[i].hi});
      chk($sformatf("v%0d_zero", i), {31'h0, ZERO}, {31'h0, vecs[i].zero});
      chk($sformatf("v%0d_ovf", i), {31'h0, OVF}, {31'h0, vecs[i].ovf});
      @(negedge CLK);
      chk($sformatf("v%0d_done_pulse", i), {30'h0, DONE, BUSY}, 32'h0);
      chk($sformatf("v%0d_result_hold", i), {24'h0, RESULT}, {24'h0, vecs[i].res});
    end

    // START during MUL is ignored; START in FIN is accepted back-to-back
    issue(3'b100, 8'hFD, 8'h05);
    @(negedge CLK);
    START = 1'b1; SELECT = 3'b001; DATA1 = 8'h05; DATA2 = 8'h05;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done(lat, busy_n, seen);
    chk("ign_done_seen", {31'h0, seen}, 32'h1);
    chk("ign_latency", lat + 1, 8);
    chk("ign_result", {16'h0, RESULT_HI, RESULT}, 32'h0000FFF1);
    chk("ign_ovf", {31'h0, OVF}, 32'h0);
    START = 1'b1; SELECT = 3'b011; DATA1 = 8'h0F; DATA2 = 8'hF0;
    @(posedge CLK);
    #1 START = 1'b0;
    @(negedge CLK);
    chk("b2b_done", {30'h0, DONE, BUSY}, 32'h2);
    chk("b2b_result", {16'h0, RESULT_HI, RESULT}, 32'h000000FF);

    // Asynchronous reset between edges during a multiply
    issue(3'b100, 8'h7F, 8'h7F);
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;
    #1 chk("rst_mid_outputs", {12'h000, RESULT, RESULT_HI, BUSY, DONE, ZERO, OVF}, 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (k == 3) RESET = 1'b1;
      chk($sformatf("rst_no_done_%0d", k), {30'h0, DONE, BUSY}, 32'h0);
    end
    issue(3'b000, 8'h00, 8'h3C);
    wait_done(lat, busy_n, seen);
    chk("post_rst_done_seen", {31'h0, seen}, 32'h1);
    chk("post_rst_latency", lat, 0);
    chk("post_rst_result", {24'h0, RESULT}, 32'h3C);

    // WIDTH=16 multiply: -32768 * -1
    @(negedge CLK);
    start16 = 1'b1; sel16 = 3'b100; a16 = 16'h8000; b16 = 16'hFFFF;
    @(posedge CLK);
    #1 start16 = 1'b0;
    lat16  = 0;
    seen16 = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(negedge CLK);
      if (done16) begin
        seen16 = 1'b1;
        break;
      end
      @(posedge CLK);
      lat16++;
    end
    chk("w16_done_seen", {31'h0, seen16}, 32'h1);
    chk("w16_latency", lat16, 16);
    chk("w16_result", {hi16, res16}, 32'h00008000);
    chk("w16_ovf", {30'h0, ovf16, zero16}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the 8-bit combinational CPU ALU. It has the same 3-bit operation encoding, generalised to WIDTH bits. It adds registered outputs, a START/BUSY/DONE handshake, an iterative signed multiplier producing the full 2*WIDTH product, iterative shifts, and OVF/ZERO flags. It sits between the register file/control unit and the writeback path. The control unit stalls on BUSY.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of two)
CNTW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
CLK  input  1  clock, rising-edge
RESET  input  1  asynchronous, active-low reset
START  input  1  request; accepted only when BUSY=0
SELECT  input  3  000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRA, 111 ROR
DATA1  input  WIDTH  operand A (shifted/multiplied operand)
DATA2  input  WIDTH  operand B (FWD source, shift amount, multiplier)
RESULT  output  WIDTH  registered result, low half for MUL
RESULT_HI  output  WIDTH  MUL high half of signed 2*WIDTH product; 0 for other ops
BUSY  output  1  operation in progress
DONE  output  1  one-cycle pulse; RESULT/flags valid from this cycle
ZERO  output  1  RESULT==0, registered with RESULT
OVF  output  1  signed overflow; 0 for FWD/AND/OR/shifts

Behaviour:
- Reset (RESET=0, async): state IDLE; RESULT, RESULT_HI, BUSY, DONE, ZERO, OVF, counter, internal regs = 0. Applies immediately, including mid-operation; the in-flight op is discarded.
- States: IDLE, MUL, SHIFT, FIN. BUSY=1 in MUL/SHIFT. DONE=1 only in FIN.
- START, SELECT, DATA1 and DATA2 are sampled only on a rising edge with START=1 and state IDLE or FIN (edge e0). START in MUL/SHIFT is ignored, not queued. Back-to-back ops: START during FIN is accepted; the next state is per the new op.
- Single-cycle ops (FWD, ADD, AND, OR) and shifts with effective count 0: results are written at e0, state -> FIN. DONE is high in the cycle after e0.
- FWD: RESULT=DATA2. AND/OR: bitwise.
- ADD: RESULT=(A+B) mod 2^WIDTH. OVF=1 when the operand signs are equal and the result sign differs.
- MUL (two's complement):
  - At e0, latch |A|, |B| (WIDTH-bit unsigned; the most-negative value maps to 2^(WIDTH-1)) and the sign flag A[MSB]^B[MSB]. Clear the accumulator; counter=WIDTH.
  - Each MUL-state edge does one shift-add step and decrements the counter.
  - The edge with counter==1 negates the 2*WIDTH product if the sign flag is set, writes RESULT_HI:RESULT and the flags, and goes to FIN.
  - DONE rises exactly WIDTH edges after e0.
  - OVF=1 when RESULT_HI is not all copies of RESULT[MSB].
- Shifts: amount n=unsigned DATA2.
  - Effective count: SLL/SRA min(n, WIDTH); ROR n mod WIDTH.
  - One 1-bit step per SHIFT-state edge, performed on an internal register loaded with A at e0. Result is written on the last step, then FIN. DONE rises count edges after e0.
  - SLL shifts in 0 (n>=WIDTH -> 0). SRA replicates the original A[MSB] (n>=WIDTH -> all sign). ROR moves bit0 into the MSB.
- RESULT, RESULT_HI and flags hold their values until the next completion. FIN -> IDLE on the next edge if no START.
- ZERO and OVF update only at completion, together with RESULT.

Test Plan:
WIDTH=8 throughout.
- ADD 0x7F+0x01: START one cycle -> next cycle DONE=1, RESULT=0x80, OVF=1, ZERO=0, BUSY never 1. Then ADD 0x01+0xFF -> RESULT=0x00, ZERO=1, OVF=0.
- MUL 0xFD(-3)*0x05: BUSY high for 8 cycles, DONE exactly 8 edges after e0 -> RESULT=0xF1, RESULT_HI=0xFF, OVF=0. MUL 0x80*0x80 -> RESULT=0x00, RESULT_HI=0x40, OVF=1, ZERO=1.
- Shifts:
  - SRA 0x90 by 2 -> 0xE4, DONE 2 edges after e0.
  - SRA 0x90 by 0 -> 0x90 after 1 cycle.
  - SLL 0x01 by 9 -> 0x00 after 8 edges.
  - ROR 0x81 by 9 -> 0xC0 after 1 edge.
- Pulse START with ADD 0x05+0x05 during a MUL in progress -> ignored, MUL result unchanged. Assert START in the FIN cycle with OR 0x0F|0xF0 -> accepted, DONE next cycle, RESULT=0xFF.
- Drive RESET=0 mid-MUL (cycle 4) between clock edges -> all outputs 0 immediately, no DONE. After release, a new FWD 0x3C completes normally with RESULT=0x3C.
- WIDTH=16 regression: MUL 0x8000*0xFFFF -> RESULT=0x8000, RESULT_HI=0x0000, OVF=1, DONE 16 edges after e0.
